// File: rtl/reg_bank_pkg.sv
// Shared types for the general-purpose register bank.
// Op codes and context save/restore engine states.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_DRIVE = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_CLR   = 3'd5
  } reg_bank_op_e;

  typedef enum logic [1:0] {
    CTX_IDLE    = 2'd0,
    CTX_SAVE    = 2'd1,
    CTX_RESTORE = 2'd2,
    CTX_DONE    = 2'd3
  } ctx_state_e;

endpackage

// File: rtl/reg_bank_ctx_fsm.sv
// Context save/restore engine: walks every register index
// and streams it to or from memory over a req/ack handshake.
module reg_bank_ctx_fsm
  import reg_bank_pkg::*;
#(
  parameter int  DATA_W   = 8,
  parameter int  NUM_REGS = 4,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctx_save,
  input  logic              ctx_restore,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy_o,
  output logic              ctx_busy,
  output logic              ctx_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [SEL_W-1:0]  mem_idx,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              rst_we,
  output logic [SEL_W-1:0]  rst_idx,
  output logic [DATA_W-1:0] rst_data
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_REGS - 1);

  ctx_state_e       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rst_we  = 1'b0;
    unique case (state_q)
      CTX_IDLE: begin
        idx_d = '0;
        if (ctx_save)         state_d = CTX_SAVE;
        else if (ctx_restore) state_d = CTX_RESTORE;
      end
      CTX_SAVE, CTX_RESTORE: begin
        rst_we = mem_ack && (state_q == CTX_RESTORE);
        if (mem_ack) begin
          if (idx_q == LAST) begin
            state_d = CTX_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
      end
      CTX_DONE: state_d = CTX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CTX_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign mem_req   = (state_q == CTX_SAVE) || (state_q == CTX_RESTORE);
  assign mem_we    = (state_q == CTX_SAVE);
  assign mem_idx   = idx_q;
  assign mem_wdata = mem_we ? wdata_i : '0;
  assign ctx_busy  = mem_req;
  assign ctx_done  = (state_q == CTX_DONE);
  assign busy_o    = (state_q != CTX_IDLE);
  assign rst_idx   = idx_q;
  assign rst_data  = mem_rdata;

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: bus ops, two direct read ports
// and a context save/restore engine toward memory.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int  DATA_W   = 8,
  parameter int  NUM_REGS = 4,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [SEL_W-1:0]  dir_a_sel,
  input  logic [SEL_W-1:0]  dir_b_sel,
  output logic [DATA_W-1:0] dir_a,
  output logic [DATA_W-1:0] dir_b,
  input  logic              ctx_save,
  input  logic              ctx_restore,
  output logic              ctx_busy,
  output logic              ctx_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [SEL_W-1:0]  mem_idx,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] sel_val;
  logic [DATA_W-1:0] save_val;
  logic [DATA_W-1:0] rst_data;
  logic [SEL_W-1:0]  rst_idx;
  logic              rst_we;
  logic              busy;
  logic              sel_ok;
  reg_bank_op_e      op_e;

  assign op_e   = reg_bank_op_e'(op);
  assign sel_ok = int'(reg_sel) < NUM_REGS;

  // Out-of-range selects read as zero
  always_comb begin
    sel_val  = '0;
    save_val = '0;
    dir_a    = '0;
    dir_b    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_sel == SEL_W'(i))   sel_val  = regs_q[i];
      if (mem_idx == SEL_W'(i))   save_val = regs_q[i];
      if (dir_a_sel == SEL_W'(i)) dir_a    = regs_q[i];
      if (dir_b_sel == SEL_W'(i)) dir_b    = regs_q[i];
    end
  end

  always_comb begin
    bus_oe  = !busy && sel_ok && (op_e == OP_DRIVE);
    bus_out = bus_oe ? sel_val : '0;
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst_we && rst_idx == SEL_W'(i)) begin
        regs_d[i] = rst_data;
      end else if (!busy && reg_sel == SEL_W'(i)) begin
        case (op_e)
          OP_LOAD: regs_d[i] = bus_in;
          OP_INC:  regs_d[i] = regs_q[i] + DATA_W'(1);
          OP_DEC:  regs_d[i] = regs_q[i] - DATA_W'(1);
          OP_CLR:  regs_d[i] = '0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_bank_ctx_fsm #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_ctx (
    .clock      (clock),
    .reset      (reset),
    .ctx_save   (ctx_save),
    .ctx_restore(ctx_restore),
    .wdata_i    (save_val),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy_o     (busy),
    .ctx_busy   (ctx_busy),
    .ctx_done   (ctx_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_idx    (mem_idx),
    .mem_wdata  (mem_wdata),
    .rst_we     (rst_we),
    .rst_idx    (rst_idx),
    .rst_data   (rst_data)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: op vector table, memory
// transaction scoreboard and context save/restore sequences.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic       clock = 0;
  logic       reset = 1;
  logic [2:0] op = OP_NOP;
  logic [1:0] reg_sel = 0;
  logic [7:0] bus_in = 0;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [1:0] dir_a_sel = 0;
  logic [1:0] dir_b_sel = 0;
  logic [7:0] dir_a, dir_b;
  logic       ctx_save = 0;
  logic       ctx_restore = 0;
  logic       ctx_busy, ctx_done;
  logic       mem_req, mem_we;
  logic [1:0] mem_idx;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 0;
  logic       mem_ack = 0;

  // five-register instance so an out-of-range select is reachable
  logic [2:0] op5 = OP_NOP;
  logic [2:0] sel5 = 0;
  logic [7:0] bus_in5 = 0;
  logic [7:0] bus_out5;
  logic       bus_oe5;
  logic [2:0] a5_sel = 0;
  logic [7:0] dir_a5, dir_b5;
  logic       busy5, done5, req5, we5;
  logic [2:0] idx5;
  logic [7:0] wdata5;

  always #5 clock = ~clock;

  reg_bank dut (
    .clock(clock), .reset(reset), .op(op), .reg_sel(reg_sel),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .dir_a_sel(dir_a_sel), .dir_b_sel(dir_b_sel),
    .dir_a(dir_a), .dir_b(dir_b),
    .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .ctx_busy(ctx_busy), .ctx_done(ctx_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  reg_bank #(.DATA_W(8), .NUM_REGS(5)) dut5 (
    .clock(clock), .reset(reset), .op(op5), .reg_sel(sel5),
    .bus_in(bus_in5), .bus_out(bus_out5), .bus_oe(bus_oe5),
    .dir_a_sel(a5_sel), .dir_b_sel(3'd0),
    .dir_a(dir_a5), .dir_b(dir_b5),
    .ctx_save(1'b0), .ctx_restore(1'b0),
    .ctx_busy(busy5), .ctx_done(done5),
    .mem_req(req5), .mem_we(we5), .mem_idx(idx5),
    .mem_wdata(wdata5), .mem_rdata(8'd0), .mem_ack(1'b0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic [1:0] idx;
    logic [7:0] data;
  } mem_exp_t;

  mem_exp_t   sb[$];
  int         done_cnt = 0;
  int         wr_cnt = 0;
  logic       hold_v = 0;
  logic [1:0] hold_idx;
  logic [7:0] hold_wd;

  always @(negedge clock) begin
    mem_exp_t e;
    if (ctx_done) done_cnt++;
    if (mem_req && hold_v) begin
      chk("hold_idx", 32'(mem_idx), 32'(hold_idx));
      chk("hold_wdata", 32'(mem_wdata), 32'(hold_wd));
    end
    hold_v   = mem_req && !mem_ack;
    hold_idx = mem_idx;
    hold_wd  = mem_wdata;
    if (mem_req && mem_ack) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_txn", 32'(mem_idx) + 32'h100, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_idx", 32'(mem_idx), 32'(e.idx));
        if (e.we) begin
          chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
          wr_cnt++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [1:0] s,
                       input logic [7:0] d);
    cyc();
    op = o;
    reg_sel = s;
    bus_in = d;
  endtask

  task automatic push_save(input logic [7:0] v [4]);
    for (int i = 0; i < 4; i++) sb.push_back('{1'b1, 2'(i), v[i]});
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (ctx_done) begin
        ok = 1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] sel;
    logic [7:0] din;
    logic [1:0] asel;
    logic [7:0] ea;
    logic       eoe;
    logic [7:0] ebus;
  } vec_t;

  vec_t       tv [10];
  logic [7:0] sv [4];
  logic [7:0] rv [4];
  int         d0;
  int         w0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{OP_LOAD,  2'd2, 8'hA5, 2'd2, 8'h00, 1'b0, 8'h00};
    tv[1] = '{OP_DRIVE, 2'd2, 8'h00, 2'd2, 8'hA5, 1'b1, 8'hA5};
    tv[2] = '{OP_LOAD,  2'd0, 8'hFF, 2'd0, 8'h00, 1'b0, 8'h00};
    tv[3] = '{OP_INC,   2'd0, 8'h00, 2'd0, 8'hFF, 1'b0, 8'h00};
    tv[4] = '{OP_DEC,   2'd1, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00};
    tv[5] = '{OP_DRIVE, 2'd1, 8'h00, 2'd1, 8'hFF, 1'b1, 8'hFF};
    tv[6] = '{OP_CLR,   2'd1, 8'h00, 2'd1, 8'hFF, 1'b0, 8'h00};
    tv[7] = '{3'd7,     2'd2, 8'h3C, 2'd1, 8'h00, 1'b0, 8'h00};
    tv[8] = '{OP_DRIVE, 2'd0, 8'h00, 2'd2, 8'hA5, 1'b1, 8'h00};
    tv[9] = '{3'd6,     2'd2, 8'h00, 2'd2, 8'hA5, 1'b0, 8'h00};
    sv = '{8'h11, 8'h22, 8'h33, 8'h44};
    rv = '{8'h5A, 8'h01, 8'h80, 8'hFE};

    repeat (3) cyc();
    reset = 0;
    @(negedge clock);
    chk("rst_bus_oe", 32'(bus_oe), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(ctx_busy), 0);
    chk("rst_done", 32'(ctx_done), 0);
    chk("rst_dir_a", 32'(dir_a), 0);

    for (int i = 0; i < 10; i++) begin
      cyc();
      op = tv[i].op;
      reg_sel = tv[i].sel;
      bus_in = tv[i].din;
      dir_a_sel = tv[i].asel;
      @(negedge clock);
      chk($sformatf("vec%0d_dir_a", i), 32'(dir_a), 32'(tv[i].ea));
      chk($sformatf("vec%0d_oe", i), 32'(bus_oe), 32'(tv[i].eoe));
      chk($sformatf("vec%0d_bus", i), 32'(bus_out), 32'(tv[i].ebus));
    end

    // out-of-range select on the five-register instance
    cyc(); op = OP_NOP;
    op5 = OP_LOAD; sel5 = 3'd7; bus_in5 = 8'h33;
    cyc(); op5 = OP_DRIVE; sel5 = 3'd7;
    @(negedge clock);
    chk("sel7_oe", 32'(bus_oe5), 0);
    chk("sel7_bus", 32'(bus_out5), 0);
    cyc(); op5 = OP_LOAD; sel5 = 3'd4; bus_in5 = 8'h44;
    cyc(); op5 = OP_DRIVE; a5_sel = 3'd4;
    @(negedge clock);
    chk("sel4_oe", 32'(bus_oe5), 1);
    chk("sel4_bus", 32'(bus_out5), 32'h44);
    chk("sel4_dir", 32'(dir_a5), 32'h44);
    op5 = OP_NOP;
    for (int i = 0; i < 4; i++) begin
      cyc(); a5_sel = 3'(i);
      @(negedge clock);
      chk($sformatf("sel7_noalias_r%0d", i), 32'(dir_a5), 0);
    end

    // save with ack every other cycle
    for (int i = 0; i < 4; i++) do_op(OP_LOAD, 2'(i), sv[i]);
    cyc(); op = OP_NOP; ctx_save = 1;
    push_save(sv);
    d0 = done_cnt; wr_cnt = 0;
    begin
      bit ok = 0;
      for (int n = 1; n < 40; n++) begin
        cyc(); ctx_save = 0; mem_ack = (n % 2 == 0);
        @(negedge clock);
        if (ctx_done) begin ok = 1; break; end
      end
      chk("save_done_seen", 32'(ok), 1);
    end
    cyc(); mem_ack = 0;
    @(negedge clock);
    chk("save_done_pulse", 32'(ctx_done), 0);
    chk("save_idle", 32'(ctx_busy), 0);
    chk("save_done_cnt", 32'(done_cnt - d0), 1);
    chk("save_writes", 32'(wr_cnt), 4);
    chk("save_sb_empty", 32'(sb.size()), 0);

    // simultaneous save+restore, blocked LOAD, ignored re-save
    cyc(); ctx_save = 1; ctx_restore = 1;
    push_save(sv);
    wr_cnt = 0; d0 = done_cnt;
    cyc(); ctx_save = 0; ctx_restore = 0;
    op = OP_LOAD; reg_sel = 0; bus_in = 8'h99; mem_ack = 1;
    dir_a_sel = 0;
    @(negedge clock);
    chk("both_busy", 32'(ctx_busy), 1);
    chk("both_we", 32'(mem_we), 1);
    chk("busy_bus_oe", 32'(bus_oe), 0);
    cyc(); op = OP_NOP; ctx_save = 1;
    cyc(); ctx_save = 0;
    wait_done("resave_done_seen");
    cyc(); mem_ack = 0;
    @(negedge clock);
    chk("busy_load_ignored", 32'(dir_a), 32'h11);
    repeat (3) cyc();
    @(negedge clock);
    chk("resave_not_queued", 32'(ctx_busy), 0);
    chk("resave_writes", 32'(wr_cnt), 4);
    chk("resave_done_cnt", 32'(done_cnt - d0), 1);

    // restore with ack every cycle
    for (int i = 0; i < 4; i++) do_op(OP_CLR, 2'(i), 8'h00);
    cyc(); op = OP_NOP; ctx_restore = 1;
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 2'(i), 8'h00});
    for (int k = 0; k < 4; k++) begin
      cyc(); ctx_restore = 0; mem_ack = 1; mem_rdata = rv[k];
    end
    cyc(); mem_ack = 0;
    @(negedge clock);
    chk("restore_done_c5", 32'(ctx_done), 1);
    cyc();
    @(negedge clock);
    chk("restore_done_pulse", 32'(ctx_done), 0);
    chk("restore_idle", 32'(ctx_busy), 0);
    chk("restore_sb_empty", 32'(sb.size()), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); dir_a_sel = 2'(i); dir_b_sel = 2'(3 - i);
      @(negedge clock);
      chk($sformatf("restore_a_r%0d", i), 32'(dir_a), 32'(rv[i]));
      chk($sformatf("restore_b_r%0d", 3 - i), 32'(dir_b),
          32'(rv[3 - i]));
    end

    // reset in the middle of a restore
    cyc(); ctx_restore = 1;
    sb.push_back('{1'b0, 2'd0, 8'h00});
    sb.push_back('{1'b0, 2'd1, 8'h00});
    d0 = done_cnt;
    cyc(); ctx_restore = 0; mem_ack = 1; mem_rdata = 8'h77;
    cyc(); mem_rdata = 8'h66;
    cyc(); mem_ack = 0; reset = 1;
    cyc(); reset = 0;
    @(negedge clock);
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_busy", 32'(ctx_busy), 0);
    chk("abort_sb_empty", 32'(sb.size()), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); dir_a_sel = 2'(i);
      @(negedge clock);
      chk($sformatf("abort_r%0d_zero", i), 32'(dir_a), 0);
      chk("abort_no_req", 32'(mem_req), 0);
    end
    chk("abort_no_done", 32'(done_cnt - d0), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
